irq_pri_ctrl: RTL
=================

Name: irq_pri_ctrl

Overview:
- 8-line interrupt request controller that sits directly upstream of the 8-to-3 priority encode stage.
- Samples request lines, detects rising edges and holds per-line pending bits, then applies an enable mask.
- Resolves the highest-priority masked-in pending line into a 3-bit id.
- Presents the id to the consumer with a valid/ack handshake, and blocks further requests until end-of-interrupt (EOI).

Parameters:
- N_IRQ, 8, number of request lines; id width is fixed at 3 for N_IRQ=8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_in  input  8  level request lines, synchronous to clk
- mask  input  8  1 = line enabled
- irq_ack  input  1  consumer accepts the presented id (1-cycle pulse)
- eoi  input  1  end of service (1-cycle pulse)
- ovf_clr  input  1  clears all overflow flags
- irq_valid  output  1  id is presented
- irq_id  output  3  index of the selected line (7 = highest priority)
- in_service  output  1  an accepted interrupt is being serviced
- pending  output  8  pending bits (registered)
- ovf  output  8  sticky per-line overflow flags

Behaviour:
- Reset (async, rst=1):
  - req_q, req_d, pending, ovf = 0.
  - irq_id = 0, irq_valid = 0, in_service = 0.
  - State = IDLE.
- Input sampling:
  - req_q <= req_in; req_d <= req_q.
  - edge = req_q & ~req_d (combinational from flops). Only rising edges create events; a held-high line produces one event.
- Pending update per bit i, each clock:
  - set if edge[i];
  - clear if (state==PEND && irq_ack && irq_id==i);
  - set wins over clear in the same cycle.
  - If edge[i] && pending[i] already 1 and not being cleared that cycle: ovf[i] <= 1.
- Overflow clear:
  - ovf_clr clears all ovf bits.
  - ovf_clr and a new overflow on the same bit in the same cycle: the set wins.
- Priority:
  - sel = highest index i with (pending[i] & mask[i]); bit 7 is highest.
  - Masked-out pending bits stay pending and are not lost.
- FSM states:
  - IDLE: if (pending & mask) != 0, latch irq_id <= sel and go to PEND. irq_valid is registered: it is 1 exactly while state==PEND.
  - PEND: irq_valid=1; irq_id is held stable and is not re-arbitrated even if a higher line arrives or mask changes.
    - On irq_ack: clear pending[irq_id] and go to INSERV.
    - Without irq_ack: stay in PEND.
  - INSERV: in_service=1, irq_valid=0. On eoi, go to IDLE. New edges are still captured as pending meanwhile.
  - eoi outside INSERV is ignored. irq_ack outside PEND is ignored.
- Latency:
  - Edge 1 samples req_in[i]=1; pending[i]=1 after edge 2.
  - irq_valid=1 after edge 3 (IDLE, line unmasked).
  - After eoi, the next pending line is presented after one IDLE cycle: IDLE is always occupied for at least one cycle.
- Reset mid-operation: immediate return to the reset values. Request lines held high through reset produce a new event after reset release, because req_d restarts at 0.
- irq_id retains its last value outside PEND and is don't-care when irq_valid=0.

Test Plan:
1. Reset, mask=FF; pulse req_in[3] high for 2 cycles.
   - irq_valid=1, irq_id=3 at edge 3, pending=08.
   - irq_ack -> pending=00, in_service=1.
   - eoi -> IDLE, irq_valid stays 0.
2. mask=FF; req_in[1] and req_in[6] rise in the same cycle.
   - Response: id=6 first; ack + eoi; then id=1 presented one IDLE cycle later.
3. mask=F7; req_in[3] rises.
   - Response: pending=08, irq_valid stays 0.
   - Then set mask=FF: irq_valid=1, id=3 on the following IDLE evaluation.
4. In PEND with id=2, req_in[5] rises.
   - Response: irq_id stays 2 until ack.
   - After ack + eoi, id=5 is presented.
5. req_in[4] toggles 0-1-0-1 with pending[4] unacked.
   - Response: ovf=10.
   - ovf_clr -> ovf=00; pending[4] remains 1.
6. Assert rst while in INSERV with pending=81.
   - Response: all outputs 0 asynchronously, before the next clk edge.
   - Lines held high re-raise pending after release: pending=81 two edges after rst drops.

Source files
------------

// File: rtl/irq_pri_ctrl.sv
// 8-line edge-captured interrupt controller: pending/overflow tracking, fixed priority (7 highest), valid/ack/EOI handshake.
// Latency: req rise -> pending after 2 clks -> irq_valid after 3; id held in PEND until irq_ack, no new id until eoi.
module irq_pri_ctrl #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] req_in,
    input  logic [N_IRQ-1:0] mask,
    input  logic             irq_ack,
    input  logic             eoi,
    input  logic             ovf_clr,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] ovf
);

    typedef enum logic [1:0] {IDLE, PEND, INSERV} state_t;

    state_t           state_q;
    logic [N_IRQ-1:0] req_q, req_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] ovf_q, ovf_d;
    logic [N_IRQ-1:0] edge_w, clr_w, act_w, ovf_set;
    logic [ID_W-1:0]  id_q, sel;
    logic             valid_q, inserv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            req_d <= '0;
        end else begin
            req_q <= req_in;
            req_d <= req_q;
        end
    end

    assign edge_w = req_q & ~req_d;
    assign act_w  = pend_q & mask;

    always_comb begin
        clr_w = '0;
        if (state_q == PEND && irq_ack) clr_w[id_q] = 1'b1;
    end

    // A fresh edge beats the ack clear, so a re-raised line stays pending.
    assign ovf_set = edge_w & pend_q & ~clr_w;
    assign pend_d  = edge_w | (pend_q & ~clr_w);
    assign ovf_d   = ovf_set | (ovf_q & ~{N_IRQ{ovf_clr}});

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (act_w[i]) sel = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            valid_q  <= 1'b0;
            inserv_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|act_w) begin
                        id_q    <= sel;
                        valid_q <= 1'b1;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (irq_ack) begin
                        valid_q  <= 1'b0;
                        inserv_q <= 1'b1;
                        state_q  <= INSERV;
                    end
                end
                INSERV: begin
                    if (eoi) begin
                        inserv_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    valid_q  <= 1'b0;
                    inserv_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign irq_valid  = valid_q;
    assign irq_id     = id_q;
    assign in_service = inserv_q;
    assign pending    = pend_q;
    assign ovf        = ovf_q;

endmodule
